// File: rtl/str_pkg.sv
// Shared types and helpers for the stream-chain blocks (decimator/interpolator family).
package str_pkg;

    typedef enum logic {ZERO_STUFF, HOLD} interp_mode_e;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with async active-low reset, synchronous clear and wrap on en & last.
module mod_counter
    import str_pkg::*;
#(
    parameter int N = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                clr,
    output logic [cnt_w(N)-1:0] cnt,
    output logic                last
);

    localparam int            CW    = cnt_w(N);
    localparam logic [CW-1:0] LASTV = CW'(N - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= last ? '0 : r_cnt + CW'(1);
        end
    end

    assign cnt  = r_cnt;
    assign last = (r_cnt == LASTV);

endmodule

// File: rtl/str_interp.sv
// Streaming integer interpolator: each accepted sample becomes INTERP output beats,
// zero-stuffed or held, with zero-bubble back-to-back groups.
module str_interp
    import str_pkg::*;
#(
    parameter int           DW     = 10,
    parameter int           INTERP = 5,
    parameter interp_mode_e MODE   = ZERO_STUFF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in,
    input  logic          ivalid,
    output logic          iready,
    output logic [DW-1:0] out,
    output logic          ovalid,
    input  logic          oready,
    output logic          ofirst,
    output logic          olast
);

    if (INTERP < 1) begin : g_bad_interp
        $error("str_interp: INTERP must be >= 1");
    end

    localparam int CW = cnt_w(INTERP);

    logic          r_busy;
    logic [DW-1:0] r_cur;
    logic [CW-1:0] w_phase;
    logic          w_last;
    logic          w_first;
    logic          w_ish;
    logic          w_osh;

    // Phase advances on every output handshake and wraps after the last beat;
    // a fresh group from idle forces it back to 0.
    mod_counter #(.N(INTERP)) u_phase (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_osh),
        .clr   (w_ish & ~r_busy),
        .cnt   (w_phase),
        .last  (w_last)
    );

    assign w_osh  = r_busy & oready;
    assign iready = ~r_busy | (w_osh & w_last);
    assign w_ish  = ivalid & iready;

    // A new sample is only accepted when idle or as the last beat leaves,
    // so cur can load on every input handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cur  <= '0;
        end else begin
            if (w_osh & w_last) begin
                r_busy <= w_ish;
            end else if (w_ish) begin
                r_busy <= 1'b1;
            end
            if (w_ish) begin
                r_cur <= in;
            end
        end
    end

    always_comb begin
        w_first = (w_phase == '0);
        out     = (w_first || MODE == HOLD) ? r_cur : '0;
        ovalid  = r_busy;
        ofirst  = r_busy & w_first;
        olast   = r_busy & w_last;
    end

endmodule

// File: tb/tb_str_interp.sv
// Randomized self-checking bench for str_interp against a beat-queue reference model.
module tb_str_interp;
    import str_pkg::*;

    localparam int DW = 10;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          f;
        logic          l;
    } beat_t;

    logic clk;
    logic rst_n;

    logic [DW-1:0] a_in,  b_in,  c_in;
    logic          a_iv,  b_iv,  c_iv;
    logic          a_or,  b_or,  c_or;
    logic          a_ird, b_ird, c_ird;
    logic [DW-1:0] a_out, b_out, c_out;
    logic          a_ov,  b_ov,  c_ov;
    logic          a_of,  b_of,  c_of;
    logic          a_ol,  b_ol,  c_ol;

    int total = 0;
    int bad   = 0;

    beat_t qa[$];
    beat_t qb[$];
    beat_t qc[$];

    str_interp #(.DW(DW), .INTERP(5), .MODE(ZERO_STUFF)) u_a (
        .clk(clk), .rst_n(rst_n), .in(a_in), .ivalid(a_iv), .iready(a_ird),
        .out(a_out), .ovalid(a_ov), .oready(a_or), .ofirst(a_of), .olast(a_ol)
    );

    str_interp #(.DW(DW), .INTERP(5), .MODE(HOLD)) u_b (
        .clk(clk), .rst_n(rst_n), .in(b_in), .ivalid(b_iv), .iready(b_ird),
        .out(b_out), .ovalid(b_ov), .oready(b_or), .ofirst(b_of), .olast(b_ol)
    );

    str_interp #(.DW(DW), .INTERP(1), .MODE(ZERO_STUFF)) u_c (
        .clk(clk), .rst_n(rst_n), .in(c_in), .ivalid(c_iv), .iready(c_ird),
        .out(c_out), .ovalid(c_ov), .oready(c_or), .ofirst(c_of), .olast(c_ol)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int qsize(input int s);
        case (s)
            0:       return qa.size();
            1:       return qb.size();
            default: return qc.size();
        endcase
    endfunction

    function automatic beat_t qfront(input int s);
        case (s)
            0:       return qa[0];
            1:       return qb[0];
            default: return qc[0];
        endcase
    endfunction

    function automatic void qpop(input int s);
        case (s)
            0:       void'(qa.pop_front());
            1:       void'(qb.pop_front());
            default: void'(qc.pop_front());
        endcase
    endfunction

    // A sample expands to n beats: sample first, then zeros or repeats.
    function automatic void push_group(input int s, input logic [DW-1:0] v);
        int    n    = (s == 2) ? 1 : 5;
        bit    hold = (s == 1);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.d = (k == 0 || hold) ? v : '0;
            b.f = (k == 0);
            b.l = (k == n - 1);
            case (s)
                0:       qa.push_back(b);
                1:       qb.push_back(b);
                default: qc.push_back(b);
            endcase
        end
    endfunction

    // Expected {ovalid, iready, ofirst, olast, out}; out is don't-care (0) when idle.
    function automatic logic [DW+3:0] expect_t(input int s, input logic ordy);
        int    sz = qsize(s);
        beat_t b;
        if (sz == 0) return {1'b0, 1'b1, 1'b0, 1'b0, {DW{1'b0}}};
        b = qfront(s);
        return {1'b1, (ordy && sz == 1), b.f, b.l, b.d};
    endfunction

    function automatic logic [DW+3:0] observe(input int s);
        case (s)
            0:       return {a_ov, a_ird, a_of, a_ol, a_out};
            1:       return {b_ov, b_ird, b_of, b_ol, b_out};
            default: return {c_ov, c_ird, c_of, c_ol, c_out};
        endcase
    endfunction

    function automatic bit advance(input int s, input logic [DW-1:0] v,
                                   input logic iv, input logic ordy);
        int sz  = qsize(s);
        bit rdy = (sz == 0) || (ordy && sz == 1);
        if (sz != 0 && ordy) qpop(s);
        if (iv && rdy) push_group(s, v);
        return iv && rdy;
    endfunction

    task automatic drive(input int s, input logic [DW-1:0] v, input logic iv, input logic ordy);
        @(negedge clk);
        case (s)
            0:       begin a_in = v; a_iv = iv; a_or = ordy; end
            1:       begin b_in = v; b_iv = iv; b_or = ordy; end
            default: begin c_in = v; c_iv = iv; c_or = ordy; end
        endcase
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [DW+3:0] o;
        #3;
        for (int s = 0; s < 3; s++) begin
            o = observe(s);
            total++;
            if (o !== {1'b0, 1'b1, 1'b0, 1'b0, {DW{1'b0}}}) begin
                bad++;
                $display("FAIL reset inst=%0d got=%h want=%h", s, o, {1'b0, 1'b1, 1'b0, 1'b0, {DW{1'b0}}});
            end
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_zero_stuff();
        int            want [15] = '{100, 0, 0, 0, 0, -7, 0, 0, 0, 0, 3, 0, 0, 0, 0};
        logic [DW-1:0] src [4];
        int            got[$];
        int            cyc[$];
        bit            fst[$];
        logic [DW+3:0] e, o;
        int            idx = 0;
        logic          iv;
        src[0] = 10'd100; src[1] = DW'(-7); src[2] = 10'd3; src[3] = '0;
        for (int c = 0; c < 40 && !(idx == 3 && qsize(0) == 0); c++) begin
            iv = (idx < 3);
            drive(0, src[idx], iv, 1'b1);
            e = expect_t(0, 1'b1);
            o = observe(0);
            if (!e[DW+3]) o[DW-1:0] = '0;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL zero_stuff cyc=%0d got=%h want=%h", c, o, e);
            end
            if (o[DW+3]) begin
                got.push_back(int'($signed(o[DW-1:0])));
                cyc.push_back(c);
                fst.push_back(o[DW+1]);
            end
            if (advance(0, src[idx], iv, 1'b1)) idx++;
        end
        total++;
        if (got.size() != 15) begin
            bad++;
            $display("FAIL zero_stuff_count got=%0d want=15", got.size());
        end else begin
            for (int i = 0; i < 15; i++) begin
                total++;
                if (got[i] != want[i] || fst[i] !== (i % 5 == 0)) begin
                    bad++;
                    $display("FAIL zero_stuff_seq beat=%0d got=%0d/%0b want=%0d/%0b",
                             i, got[i], fst[i], want[i], (i % 5 == 0));
                end
            end
            total++;
            if (cyc[14] - cyc[0] != 14) begin
                bad++;
                $display("FAIL zero_stuff_gap span=%0d want=14", cyc[14] - cyc[0]);
            end
        end
    endtask

    task automatic test_hold();
        logic [DW-1:0] src [4];
        int            got[$];
        bit            lst[$];
        int            want;
        logic [DW+3:0] e, o;
        int            idx = 0;
        logic          iv;
        src[0] = 10'd100; src[1] = DW'(-7); src[2] = 10'd3; src[3] = '0;
        for (int c = 0; c < 40 && !(idx == 3 && qsize(1) == 0); c++) begin
            iv = (idx < 3);
            drive(1, src[idx], iv, 1'b1);
            e = expect_t(1, 1'b1);
            o = observe(1);
            if (!e[DW+3]) o[DW-1:0] = '0;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL hold cyc=%0d got=%h want=%h", c, o, e);
            end
            if (o[DW+3]) begin
                got.push_back(int'($signed(o[DW-1:0])));
                lst.push_back(o[DW]);
            end
            if (advance(1, src[idx], iv, 1'b1)) idx++;
        end
        total++;
        if (got.size() != 15) begin
            bad++;
            $display("FAIL hold_count got=%0d want=15", got.size());
        end else begin
            for (int i = 0; i < 15; i++) begin
                want = (i < 5) ? 100 : (i < 10) ? -7 : 3;
                total++;
                if (got[i] != want || lst[i] !== (i % 5 == 4)) begin
                    bad++;
                    $display("FAIL hold_seq beat=%0d got=%0d/%0b want=%0d/%0b",
                             i, got[i], lst[i], want, (i % 5 == 4));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit            ord_tab [8] = '{1, 1, 0, 0, 1, 1, 1, 1};
        logic [DW-1:0] v [3];
        logic [DW+3:0] e, o, prev_o;
        logic          prev_stall = 1'b0;
        logic          ordy, iv;
        int            idx = 0;
        int            taken = 0;
        v[0] = DW'($urandom); v[1] = DW'($urandom); v[2] = '0;
        prev_o = '0;
        for (int c = 0; c < 30 && !(idx == 2 && qsize(0) == 0); c++) begin
            ordy = (c < 8) ? ord_tab[c] : 1'b1;
            iv   = (idx < 2);
            drive(0, v[idx], iv, ordy);
            e = expect_t(0, ordy);
            o = observe(0);
            if (!e[DW+3]) o[DW-1:0] = '0;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL backpressure cyc=%0d got=%h want=%h", c, o, e);
            end
            if (prev_stall) begin
                total++;
                if ({o[DW+3], o[DW+1:0]} !== {prev_o[DW+3], prev_o[DW+1:0]}) begin
                    bad++;
                    $display("FAIL stall_hold cyc=%0d got=%h want=%h", c, o, prev_o);
                end
            end
            prev_stall = o[DW+3] && !ordy;
            prev_o     = o;
            if (o[DW+3] && ordy) taken++;
            if (advance(0, v[idx], iv, ordy)) idx++;
        end
        total++;
        if (taken != 10) begin
            bad++;
            $display("FAIL backpressure_beats got=%0d want=10", taken);
        end
    endtask

    task automatic test_single_pulse();
        logic [DW+3:0] e, o;
        logic [DW-1:0] v;
        logic          iv;
        int            taken = 0;
        for (int c = 0; c < 10; c++) begin
            iv = (c == 0);
            v  = DW'($urandom);
            drive(0, v, iv, 1'b1);
            e = expect_t(0, 1'b1);
            o = observe(0);
            if (!e[DW+3]) o[DW-1:0] = '0;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL single_pulse cyc=%0d got=%h want=%h", c, o, e);
            end
            if (o[DW+3]) taken++;
            void'(advance(0, v, iv, 1'b1));
        end
        total++;
        if (taken != 5 || a_ov !== 1'b0 || a_ird !== 1'b1) begin
            bad++;
            $display("FAIL single_pulse_end beats=%0d ov=%b ird=%b want 5/0/1", taken, a_ov, a_ird);
        end
    endtask

    task automatic test_interp1();
        logic [DW+3:0] e, o;
        logic [DW-1:0] v;
        logic          iv, ordy;
        int            sent[$];
        int            recv[$];
        for (int c = 0; c < 200; c++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            v    = DW'($urandom);
            drive(2, v, iv, ordy);
            e = expect_t(2, ordy);
            o = observe(2);
            if (!e[DW+3]) o[DW-1:0] = '0;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL interp1 cyc=%0d got=%h want=%h", c, o, e);
            end
            if (o[DW+3] && ordy) recv.push_back(int'(o[DW-1:0]));
            if (advance(2, v, iv, ordy)) sent.push_back(int'(v));
        end
        drive(2, '0, 1'b0, 1'b1);
        if (c_ov) recv.push_back(int'(c_out));
        void'(advance(2, '0, 1'b0, 1'b1));
        total++;
        if (recv != sent) begin
            bad++;
            $display("FAIL interp1_order got=%0d want=%0d samples", recv.size(), sent.size());
        end
    endtask

    task automatic test_async_reset();
        logic [DW+3:0] e, o;
        logic [DW-1:0] v;
        logic          iv;
        v = DW'($urandom);
        drive(0, v, 1'b1, 1'b1);
        void'(advance(0, v, 1'b1, 1'b1));
        for (int k = 0; k < 2; k++) begin
            drive(0, '0, 1'b0, 1'b1);
            void'(advance(0, '0, 1'b0, 1'b1));
        end
        drive(0, '0, 1'b0, 1'b0);
        e = expect_t(0, 1'b0);
        o = observe(0);
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL reset_pre_phase2 got=%h want=%h", o, e);
        end
        #2 rst_n = 1'b0;
        #1;
        o = observe(0);
        total++;
        if (o !== {1'b0, 1'b1, 1'b0, 1'b0, {DW{1'b0}}}) begin
            bad++;
            $display("FAIL async_reset got=%h want=%h", o, {1'b0, 1'b1, 1'b0, 1'b0, {DW{1'b0}}});
        end
        qa.delete(); qb.delete(); qc.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        v = DW'($urandom) | DW'(1);
        for (int c = 0; c < 8; c++) begin
            iv = (c == 0);
            drive(0, v, iv, 1'b1);
            e = expect_t(0, 1'b1);
            o = observe(0);
            if (!e[DW+3]) o[DW-1:0] = '0;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL post_reset cyc=%0d got=%h want=%h", c, o, e);
            end
            void'(advance(0, v, iv, 1'b1));
        end
    endtask

    task automatic test_back_to_back();
        logic [DW+3:0] e, o;
        logic [DW-1:0] v;
        logic          iv, ordy;
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < 300; c++) begin
                iv   = ($urandom_range(0, 4) != 0);
                ordy = ($urandom_range(0, 4) != 0);
                v    = DW'($urandom);
                drive(s, v, iv, ordy);
                e = expect_t(s, ordy);
                o = observe(s);
                if (!e[DW+3]) o[DW-1:0] = '0;
                total++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL back_to_back inst=%0d cyc=%0d got=%h want=%h", s, c, o, e);
                end
                void'(advance(s, v, iv, ordy));
            end
            for (int c = 0; c < 20 && qsize(s) != 0; c++) begin
                drive(s, '0, 1'b0, 1'b1);
                void'(advance(s, '0, 1'b0, 1'b1));
            end
            total++;
            if (qsize(s) != 0) begin
                bad++;
                $display("FAIL back_to_back_drain inst=%0d left=%0d want=0", s, qsize(s));
            end
        end
    endtask

    initial begin
        clk   = 1'b0;
        rst_n = 1'b0;
        a_in = '0; b_in = '0; c_in = '0;
        a_iv = 1'b0; b_iv = 1'b0; c_iv = 1'b0;
        a_or = 1'b1; b_or = 1'b1; c_or = 1'b1;
        test_reset();
        test_zero_stuff();
        test_hold();
        test_backpressure();
        test_single_pulse();
        test_interp1();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
